// File: rtl/fanout_broadcast_stage_if.sv
// Handshake bundle for fanout_broadcast_stage: one source valid/ready port and
// NUM_LOADS consumer valid/ready pairs sharing a single broadcast data word.
interface fanout_broadcast_stage_if #(
   parameter int WIDTH     = 8,
   parameter int NUM_LOADS = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [NUM_LOADS-1:0] load_en;
   logic [NUM_LOADS-1:0] out_valid;
   logic [NUM_LOADS-1:0] out_ready;
   logic [WIDTH-1:0]     out_data;

   modport master (
      output in_valid, in_data, load_en, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, load_en, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fanout_broadcast_stage.sv
// Elastic register pipeline feeding a broadcast register with per-load acceptance tracking.
// Optional saturating statistics counters are enabled by defining FANOUT_BROADCAST_STATS_EN.
module fanout_broadcast_stage #(
   parameter int WIDTH      = 8,
   parameter int NUM_LOADS  = 4,
   parameter int PIPE_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   fanout_broadcast_stage_if.slave     bus,
   output logic                        busy
`ifdef FANOUT_BROADCAST_STATS_EN
   ,
   output logic [31:0]                 stat_words,
   output logic [31:0]                 stat_stall
`endif
);

   logic                 bcast_valid;
   logic [WIDTH-1:0]     bcast_data;
   logic [NUM_LOADS-1:0] pending;
   logic [NUM_LOADS-1:0] pending_next;
   logic                 bcast_free;
   logic                 bcast_accept;
   logic                 feed_valid;
   logic [WIDTH-1:0]     feed_data;

   assign bus.out_valid = bcast_valid ? pending : '0;
   assign bus.out_data  = bcast_data;
   assign pending_next  = pending & ~(bus.out_valid & bus.out_ready);
   // The register frees in the same cycle the last outstanding load accepts.
   assign bcast_free    = bcast_valid && (pending_next == '0);
   assign bcast_accept  = !bcast_valid || bcast_free;

   generate
      if (PIPE_DEPTH == 0) begin : g_direct
         assign feed_valid   = bus.in_valid;
         assign feed_data    = bus.in_data;
         assign bus.in_ready = bcast_accept;
         assign busy         = bcast_valid;
      end else begin : g_pipe
         logic [PIPE_DEPTH-1:0] pipe_valid;
         logic [WIDTH-1:0]      pipe_data [PIPE_DEPTH];
         logic [PIPE_DEPTH:0]   src_valid;
         logic [WIDTH-1:0]      src_data  [PIPE_DEPTH+1];
         logic [PIPE_DEPTH:0]   accept;

         assign src_valid = {pipe_valid, bus.in_valid};

         // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
         always_comb begin
            accept             = '0;
            accept[PIPE_DEPTH] = bcast_accept;
            for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
               accept[i] = !pipe_valid[i] || accept[i+1];
            end
         end

         always_comb begin
            src_data[0] = bus.in_data;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
               src_data[i+1] = pipe_data[i];
            end
         end

         // NOTE: state uses non-blocking assignments so all stages sample the pre-edge values.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pipe_valid <= '0;
            end else begin
               for (int i = 0; i < PIPE_DEPTH; i++) begin
                  if (accept[i]) pipe_valid[i] <= src_valid[i];
               end
            end
         end

         // NOTE: payload registers are not reset; their valid bits alone qualify them.
         always_ff @(posedge clk) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
               if (accept[i] && src_valid[i]) pipe_data[i] <= src_data[i];
            end
         end

         assign feed_valid   = src_valid[PIPE_DEPTH];
         assign feed_data    = src_data[PIPE_DEPTH];
         assign bus.in_ready = accept[0];
         assign busy         = (|pipe_valid) || bcast_valid;
      end
   endgenerate

   // out_data must read zero after reset, so the broadcast payload is reset too.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bcast_valid <= 1'b0;
         bcast_data  <= '0;
         pending     <= '0;
      end else if (bcast_accept && feed_valid) begin
         bcast_valid <= 1'b1;
         bcast_data  <= feed_data;
         pending     <= bus.load_en;
      end else if (bcast_free) begin
         bcast_valid <= 1'b0;
         pending     <= '0;
      end else begin
         pending     <= pending_next;
      end
   end

`ifdef FANOUT_BROADCAST_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_words <= '0;
         stat_stall <= '0;
      end else begin
         if (bcast_free && (stat_words != 32'hFFFF_FFFF)) stat_words <= stat_words + 32'd1;
         if (bcast_valid && !bcast_free && (stat_stall != 32'hFFFF_FFFF)) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fanout_broadcast_stage.sv
// Directed bench for fanout_broadcast_stage (WIDTH=8, NUM_LOADS=4, PIPE_DEPTH=2).
// Stats checks compile in when FANOUT_BROADCAST_STATS_EN is defined.
module tb_fanout_broadcast_stage;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   tests    = 0;
   int   failures = 0;
`ifdef FANOUT_BROADCAST_STATS_EN
   logic [31:0] stat_words;
   logic [31:0] stat_stall;
`endif

   fanout_broadcast_stage_if #(.WIDTH(8), .NUM_LOADS(4)) bus ();

   fanout_broadcast_stage #(
      .WIDTH(8), .NUM_LOADS(4), .PIPE_DEPTH(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
`ifdef FANOUT_BROADCAST_STATS_EN
      ,
      .stat_words (stat_words),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.load_en   = 4'hF;
      bus.out_ready = 4'hF;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_out_data", 32'(bus.out_data), 32'h0);

      // Latency: transfer edge plus two more edges
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      #1;
      check("lat_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      check("lat_edge1", 32'(bus.out_valid), 32'h0);
      tick(); #1;
      check("lat_edge2", 32'(bus.out_valid), 32'h0);
      tick(); #1;
      check("lat_valid", 32'(bus.out_valid), 32'hF);
      check("lat_data", 32'(bus.out_data), 32'hA5);
      check("lat_busy", 32'(busy), 32'h1);
      tick(); #1;
      check("lat_done_valid", 32'(bus.out_valid), 32'h0);
      check("lat_done_busy", 32'(busy), 32'h0);

      // Staggered accept with the pipeline filled behind the word
      bus.out_ready = 4'h0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h3C;
      tick(); bus.in_data = 8'h40;
      tick(); bus.in_data = 8'h41;
      tick(); bus.in_data = 8'h42;
      #1;
      check("stag_full_ready", 32'(bus.in_ready), 32'h0);
      check("stag_t0_valid", 32'(bus.out_valid), 32'hF);
      check("stag_t0_data", 32'(bus.out_data), 32'h3C);
      bus.out_ready = 4'b0001;
      #1;
      check("stag_t0_ready", 32'(bus.in_ready), 32'h0);
      tick();
      bus.out_ready = 4'b0100;
      #1;
      check("stag_t1_valid", 32'(bus.out_valid), 32'hE);
      check("stag_t1_ready", 32'(bus.in_ready), 32'h0);
      tick();
      bus.out_ready = 4'b0000;
      #1;
      check("stag_t2_valid", 32'(bus.out_valid), 32'hA);
      check("stag_t2_ready", 32'(bus.in_ready), 32'h0);
      tick();
      bus.out_ready = 4'b1010;
      #1;
      check("stag_t3_valid", 32'(bus.out_valid), 32'hA);
      check("stag_t3_data", 32'(bus.out_data), 32'h3C);
      check("stag_t3_ready", 32'(bus.in_ready), 32'h1);
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 4'hF;
      #1;
      check("stag_t4_valid", 32'(bus.out_valid), 32'hF);
      check("stag_t4_data", 32'(bus.out_data), 32'h40);
      tick(); #1;
      check("stag_drain_41", 32'(bus.out_data), 32'h41);
      tick(); #1;
      check("stag_drain_42", 32'(bus.out_data), 32'h42);
      tick(); #1;
      check("stag_drain_busy", 32'(busy), 32'h0);

      // Masked loads
      bus.load_en   = 4'b0101;
      bus.out_ready = 4'h0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h55;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick(); #1;
      check("mask_valid", 32'(bus.out_valid), 32'h5);
      check("mask_data", 32'(bus.out_data), 32'h55);
      bus.out_ready = 4'hF;
      #1;
      check("mask_valid_ready", 32'(bus.out_valid), 32'h5);
      tick(); #1;
      check("mask_done_valid", 32'(bus.out_valid), 32'h0);
      check("mask_done_busy", 32'(busy), 32'h0);

      // load_en = 0: words drop silently at full rate
      bus.load_en   = 4'h0;
      bus.out_ready = 4'h0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.in_data = 8'(8'h80 + i);
         #1;
         check("drop_in_ready", 32'(bus.in_ready), 32'h1);
         check("drop_out_valid", 32'(bus.out_valid), 32'h0);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick(); #1;
      check("drop_busy", 32'(busy), 32'h0);

      // Streaming 0x00..0x0F with all loads ready
      bus.load_en   = 4'hF;
      bus.out_ready = 4'hF;
      for (int k = 0; k < 19; k++) begin
         bus.in_valid = (k < 16);
         bus.in_data  = 8'(k);
         #1;
         if (k < 16) check("stream_in_ready", 32'(bus.in_ready), 32'h1);
         if (k >= 3) begin
            check("stream_valid", 32'(bus.out_valid), 32'hF);
            check("stream_data", 32'(bus.out_data), 32'(k - 3));
         end
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      check("stream_busy", 32'(busy), 32'h0);

      // Reset while loads 1 and 3 are still pending
      bus.out_ready = 4'h0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h77;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      bus.out_ready = 4'b0101;
      #1;
      check("mid_valid_full", 32'(bus.out_valid), 32'hF);
      tick();
      bus.out_ready = 4'h0;
      #1;
      check("mid_pending", 32'(bus.out_valid), 32'hA);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_data", 32'(bus.out_data), 32'h0);
      bus.out_ready = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         check("mid_no_reemit", 32'(bus.out_valid), 32'h0);
      end

      // Single staggered word with nothing behind it; feeds the counters
      bus.out_ready = 4'h0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h3C;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      bus.out_ready = 4'b0001;
      #1;
      check("solo_t0_valid", 32'(bus.out_valid), 32'hF);
      tick();
      bus.out_ready = 4'b0100;
      #1;
      check("solo_t1_valid", 32'(bus.out_valid), 32'hE);
      tick();
      bus.out_ready = 4'b0000;
      #1;
      check("solo_t2_valid", 32'(bus.out_valid), 32'hA);
      tick();
      bus.out_ready = 4'b1010;
      #1;
      check("solo_t3_valid", 32'(bus.out_valid), 32'hA);
      tick();
      bus.out_ready = 4'hF;
      #1;
      check("solo_t4_valid", 32'(bus.out_valid), 32'h0);
      check("solo_t4_busy", 32'(busy), 32'h0);
`ifdef FANOUT_BROADCAST_STATS_EN
      check("stat_words", stat_words, 32'd1);
      check("stat_stall", stat_stall, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
